// File: rtl/led_rgb_pwm.sv
// led_rgb_pwm: N_LED RGB LEDs, per-colour PWM with off / steady / blink / breathe modes.
// Define LED_RGB_BREATHE_EN to build breathe mode; otherwise mode 11 acts as steady.
module led_rgb_pwm #(
   parameter int N_LED      = 4,
   parameter int PWM_W      = 8,
   parameter int PRESCALE   = 256,
   parameter int ACTIVE_LOW = 1,
   localparam int AW        = (N_LED > 1) ? $clog2(N_LED) : 1
) (
   input  logic                 fpga_sysclk,
   input  logic                 rst_sys,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [AW-1:0]        wr_addr,
   input  logic [1:0]           wr_mode,
   input  logic [3*PWM_W-1:0]   wr_rgb,
   output logic [3*N_LED-1:0]   led_rgb,
   output logic                 period_end
);

   localparam int               PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [PWM_W-1:0] SLOT_LAST = '1;

   logic [PS_W-1:0]    presc_q, presc_d;
   logic [PWM_W-1:0]   slot_q, slot_d;
   logic [PWM_W:0]     frame_q, frame_d;
   logic               pend_valid_q, pend_valid_d;
   logic [AW-1:0]      pend_addr_q, pend_addr_d;
   logic [1:0]         pend_mode_q, pend_mode_d;
   logic [3*PWM_W-1:0] pend_rgb_q, pend_rgb_d;
   logic [3*N_LED-1:0] on_q, on_d;
   logic               period_end_q;
   logic               tick, wrap;

   always_comb begin
      tick         = (presc_q == PS_LAST);
      wrap         = tick && (slot_q == SLOT_LAST);
      presc_d      = tick ? '0 : presc_q + 1'b1;
      slot_d       = tick ? slot_q + 1'b1 : slot_q;
      frame_d      = wrap ? frame_q + 1'b1 : frame_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_mode_d  = pend_mode_q;
      pend_rgb_d   = pend_rgb_q;
      // A write landing in the period-end cycle is only captured here; it commits next period.
      if (pend_valid_q) begin
         if (wrap) pend_valid_d = 1'b0;
      end else if (wr_valid) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = wr_addr;
         pend_mode_d  = wr_mode;
         pend_rgb_d   = wr_rgb;
      end
   end

   always_ff @(posedge fpga_sysclk or posedge rst_sys) begin
      if (rst_sys) begin
         presc_q      <= '0;
         slot_q       <= '0;
         frame_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_mode_q  <= '0;
         pend_rgb_q   <= '0;
         on_q         <= '0;
         period_end_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         slot_q       <= slot_d;
         frame_q      <= frame_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_mode_q  <= pend_mode_d;
         pend_rgb_q   <= pend_rgb_d;
         on_q         <= on_d;
         period_end_q <= wrap;
      end
   end

`ifdef LED_RGB_BREATHE_EN
   logic [PWM_W-1:0] env;
   assign env = frame_q[PWM_W] ? ~frame_q[PWM_W-1:0] : frame_q[PWM_W-1:0];
`endif

   for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
      logic [1:0]         mode_q, mode_d;
      logic [3*PWM_W-1:0] rgb_q, rgb_d;
      logic               commit;

      // Out-of-range addresses never match any LED index, so they are silently dropped.
      assign commit = wrap && pend_valid_q && (pend_addr_q == AW'(gi));

      always_comb begin
         mode_d = mode_q;
         rgb_d  = rgb_q;
         if (commit) begin
            mode_d = pend_mode_q;
            rgb_d  = pend_rgb_q;
         end
      end

      always_ff @(posedge fpga_sysclk or posedge rst_sys) begin
         if (rst_sys) begin
            mode_q <= 2'b00;
            rgb_q  <= '0;
         end else begin
            mode_q <= mode_d;
            rgb_q  <= rgb_d;
         end
      end

      for (genvar ci = 0; ci < 3; ci++) begin : g_col
         logic [PWM_W-1:0] duty, eff;
         assign duty = rgb_q[ci*PWM_W +: PWM_W];
`ifdef LED_RGB_BREATHE_EN
         logic [2*PWM_W-1:0] prod;
         assign prod = duty * env;
`endif
         always_comb begin
            eff = duty;
            case (mode_q)
               2'b00:   eff = '0;
               2'b10:   if (frame_q[PWM_W]) eff = '0;
`ifdef LED_RGB_BREATHE_EN
               2'b11:   eff = prod[2*PWM_W-1:PWM_W];
`endif
               default: eff = duty;
            endcase
         end
         // Strict compare: duty 0 never lights, full-scale duty misses only the last slot.
         assign on_d[3*gi + ci] = (eff > slot_q);
      end
   end

   assign wr_ready   = ~pend_valid_q;
   assign period_end = period_end_q;
   assign led_rgb    = on_q ^ {(3*N_LED){ACTIVE_LOW != 0}};

endmodule
